// File: rtl/segment_display_driver_pkg.sv
// Shared types, display codes and sizing helpers for the 7-segment driver.
package General;

  // Non-numeric digit codes held in the 4-bit display cells
  localparam logic [3:0] Empty = 4'hA;
  localparam logic [3:0] Minus = 4'hB;

  typedef enum logic [1:0] {IDLE, CONVERT, FORMAT, COMMIT} display_state_t;

  // ceil(log2(v)), at least 0
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // smallest n with 10**n >= v
  function automatic int clog10(input longint v);
    int     r;
    longint p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 10;
      r = r + 1;
    end
    return r;
  endfunction

  // Digits needed to show any Size-bit value; signed adds a sign position
  function automatic int DefaultDigits(input int Size, input int Signed);
    if (Signed != 0)
      return clog10((longint'(1) << (Size - 1)) + 1) + 1;
    return clog10(longint'(1) << Size);
  endfunction

  // Digit code to active-low {DP, g..a}; DP left dark
  function automatic logic [7:0] BCD2ESC(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      Minus:   return 8'hBF;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/segment_display_driver_bcd.sv
// Serial double-dabble: loads on Start, then one shift-add-3 per clock for
// Size clocks. Done is high for one cycle once the BCD field is final.
module bin2bcd_serial import General::*; #(
  parameter int Size   = 8,
  parameter int Digits = 3
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  Start,
  input  logic [Size-1:0]       Bin,
  output logic [4*Digits-1:0]   BCD,
  output logic                  Overflow,
  output logic                  Done
);

  localparam int CW = clog2(Size + 1);

  logic [Size-1:0]     sh;
  logic [CW-1:0]       cnt;
  logic                busy;
  logic [4*Digits-1:0] adj;

  // add 3 to every digit >= 5 ahead of the shift
  always_comb begin
    adj = BCD;
    for (int i = 0; i < Digits; i++)
      if (BCD[4*i +: 4] >= 4'd5) adj[4*i +: 4] = BCD[4*i +: 4] + 4'd3;
  end

  // shift binary MSB into the BCD field; anything leaving the top is overflow
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sh       <= '0;
      BCD      <= '0;
      Overflow <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
    end else if (Start) begin
      sh       <= Bin;
      BCD      <= '0;
      Overflow <= 1'b0;
      cnt      <= CW'(Size);
      busy     <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        BCD      <= {adj[4*Digits-2:0], sh[Size-1]};
        Overflow <= Overflow | adj[4*Digits-1];
        sh       <= sh << 1;
        cnt      <= cnt - 1'b1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign Done = busy && (cnt == '0);

endmodule

// File: rtl/segment_display_driver_tick.sv
// Divide-by-N strobe: one-cycle Pulse every N clocks.
module SelectNPulse import General::*; #(
  parameter int N = 4
) (
  input  logic Clock,
  input  logic nReset,
  output logic Pulse
);

  localparam int CW = (N > 1) ? clog2(N) : 1;

  logic [CW-1:0] cnt;

  // count 0..N-1 and strobe on wrap
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cnt   <= '0;
      Pulse <= 1'b0;
    end else if (cnt == CW'(N - 1)) begin
      cnt   <= '0;
      Pulse <= 1'b1;
    end else begin
      cnt   <= cnt + 1'b1;
      Pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/segment_display_driver.sv
// Multiplexed common-anode 7-segment driver: handshake in, serial BCD
// conversion, sign/blank/dot formatting, digit scan and PWM dimming.
module segment_display_driver import General::*; #(
  parameter int Size           = 8,
  parameter int Signed         = 0,
  parameter int Digits         = 3,
  parameter int ClockPeriod_ns = 20,
  parameter int RefreshTime_ns = 20_000,
  parameter int BrightnessBits = 4
) (
  input  logic                        Clock,
  input  logic                        nReset,
  input  logic                        Valid,
  output logic                        Ready,
  input  logic [Size-1:0]             Data,
  input  logic [clog2(Digits+1)-1:0]  DotPos,
  input  logic                        BlankZeros,
  input  logic [BrightnessBits-1:0]   Brightness,
  output logic [Digits-1:0]           Indicators,
  output logic [7:0]                  Segments
);

  localparam int DW       = clog2(Digits + 1);
  localparam int IW       = (Digits > 1) ? clog2(Digits) : 1;
  localparam int MAGD     = (Signed != 0) ? Digits - 1 : Digits;
  localparam int PS_RAW   = RefreshTime_ns / ClockPeriod_ns / Digits;
  localparam int PRESCALE = (PS_RAW < 1) ? 1 : PS_RAW;

  display_state_t          state;
  logic [DW-1:0]           dot_q, dot_disp, fdot;
  logic                    blank_q, neg_q;
  logic [Digits-1:0][3:0]  disp_q, fdig;
  logic                    start, neg_in, ovf, lead;
  logic [Size-1:0]         mag;
  logic [4*Digits-1:0]     bcd;
  logic                    eng_ovf, eng_done;
  int                      msd;
  logic [IW-1:0]           idx;
  logic [BrightnessBits-1:0] pwm_cnt, bright_q;
  logic                    lit;
  logic [7:0]              cur_seg;

  // accept only from IDLE; negative inputs convert as their magnitude
  assign start  = (state == IDLE) && Valid;
  assign neg_in = (Signed != 0) && Data[Size-1];
  assign mag    = neg_in ? (~Data + 1'b1) : Data;

  bin2bcd_serial #(.Size(Size), .Digits(Digits)) u_bcd (
    .Clock    (Clock),
    .nReset   (nReset),
    .Start    (start),
    .Bin      (mag),
    .BCD      (bcd),
    .Overflow (eng_ovf),
    .Done     (eng_done)
  );

  // overflow, sign and leading-zero rules applied to the held BCD result
  always_comb begin
    fdig = '0;
    msd  = 0;
    lead = blank_q;
    ovf  = eng_ovf;
    if (Signed != 0) ovf = eng_ovf || (bcd[4*Digits-1 -: 4] != 4'd0);
    for (int i = 0; i < Digits; i++) fdig[i] = bcd[4*i +: 4];
    if (Signed != 0) fdig[Digits-1] = Empty;
    // blank from the left; digit 0 and the dotted digit always stay
    for (int i = MAGD - 1; i >= 1; i--) begin
      if (lead && fdig[i] == 4'd0 && dot_q != DW'(i + 1)) fdig[i] = Empty;
      else lead = 1'b0;
    end
    for (int i = 0; i < MAGD; i++)
      if (fdig[i] != Empty) msd = i;
    // minus sits just left of the most significant shown digit
    if ((Signed != 0) && neg_q)
      for (int i = 1; i < Digits; i++)
        if (i == msd + 1) fdig[i] = Minus;
    fdot = dot_q;
    if (ovf) begin
      for (int i = 0; i < Digits; i++) fdig[i] = Minus;
      fdot = '0;
    end
  end

  // control FSM; the display register only moves on FORMAT->COMMIT, so the
  // scan never shows a half-updated value and Ready rises one cycle later
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      Ready    <= 1'b1;
      dot_q    <= '0;
      blank_q  <= 1'b0;
      neg_q    <= 1'b0;
      disp_q   <= {Digits{Empty}};
      dot_disp <= '0;
    end else begin
      case (state)
        IDLE: if (Valid) begin
          dot_q   <= DotPos;
          blank_q <= BlankZeros;
          neg_q   <= neg_in;
          Ready   <= 1'b0;
          state   <= CONVERT;
        end
        CONVERT: if (eng_done) state <= FORMAT;
        FORMAT: begin
          disp_q   <= fdig;
          dot_disp <= fdot;
          state    <= COMMIT;
        end
        default: begin
          Ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  generate
    if (Digits > 1) begin : g_scan
      logic tick;
      SelectNPulse #(.N(PRESCALE)) u_tick (
        .Clock  (Clock),
        .nReset (nReset),
        .Pulse  (tick)
      );
      // advance the scanned digit on each tick, wrapping at the top
      always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)   idx <= '0;
        else if (tick) idx <= (idx == IW'(Digits - 1)) ? '0 : idx + 1'b1;
      end
    end else begin : g_noscan
      assign idx = '0;
    end
  endgenerate

  // free-running PWM; brightness only changes at the period boundary
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pwm_cnt  <= '0;
      bright_q <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '0) bright_q <= Brightness;
    end
  end

  assign lit = pwm_cnt < bright_q;

  // segment pattern for the scanned digit, DP lit when it carries the dot
  always_comb begin
    cur_seg = BCD2ESC(disp_q[idx]);
    if (int'(dot_disp) == int'(idx) + 1) cur_seg[7] = 1'b0;
  end

  // registered pin drivers; dark phase forces everything off
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Indicators <= '1;
      Segments   <= 8'hFF;
    end else if (lit) begin
      Indicators <= ~(Digits'(1) << idx);
      Segments   <= cur_seg;
    end else begin
      Indicators <= '1;
      Segments   <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_segment_display_driver.sv
// Bench for segment_display_driver: three configurations share the clock and
// data inputs; expected digit patterns go through a scoreboard queue.
module tb_segment_display_driver;

  localparam int SIZE = 8;
  localparam int LAT  = SIZE + 3;

  typedef struct {
    int              inst;
    logic [7:0]      data;
    logic [2:0]      dot;
    logic            blank;
    logic [3:0][7:0] exp;
  } vec_t;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic [2:0] v = '0;
  logic       rdy0, rdy1, rdy2;
  logic [7:0] data = '0;
  logic [2:0] dot = '0;
  logic       bz = 1'b0;
  logic [3:0] br = 4'd15;
  logic [2:0] ind0;
  logic [3:0] ind1;
  logic [1:0] ind2;
  logic [7:0] seg0, seg1, seg2;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[10];
  vec_t sb[$];

  always #10 Clock = ~Clock;

  segment_display_driver #(.Size(SIZE), .Signed(0), .Digits(3), .ClockPeriod_ns(20),
    .RefreshTime_ns(300), .BrightnessBits(4)) u0 (
    .Clock(Clock), .nReset(nReset), .Valid(v[0]), .Ready(rdy0), .Data(data),
    .DotPos(dot[1:0]), .BlankZeros(bz), .Brightness(br), .Indicators(ind0), .Segments(seg0));

  segment_display_driver #(.Size(SIZE), .Signed(1), .Digits(4), .ClockPeriod_ns(20),
    .RefreshTime_ns(400), .BrightnessBits(4)) u1 (
    .Clock(Clock), .nReset(nReset), .Valid(v[1]), .Ready(rdy1), .Data(data),
    .DotPos(dot), .BlankZeros(bz), .Brightness(br), .Indicators(ind1), .Segments(seg1));

  segment_display_driver #(.Size(SIZE), .Signed(0), .Digits(2), .ClockPeriod_ns(20),
    .RefreshTime_ns(200), .BrightnessBits(4)) u2 (
    .Clock(Clock), .nReset(nReset), .Valid(v[2]), .Ready(rdy2), .Data(data),
    .DotPos(dot[1:0]), .BlankZeros(bz), .Brightness(br), .Indicators(ind2), .Segments(seg2));

  function automatic int nd(input int k);
    return (k == 0) ? 3 : (k == 1) ? 4 : 2;
  endfunction

  function automatic logic rdy_of(input int k);
    return (k == 0) ? rdy0 : (k == 1) ? rdy1 : rdy2;
  endfunction

  function automatic logic [3:0] ind_of(input int k);
    return (k == 0) ? {1'b1, ind0} : (k == 1) ? ind1 : {2'b11, ind2};
  endfunction

  function automatic logic [7:0] seg_of(input int k);
    return (k == 0) ? seg0 : (k == 1) ? seg1 : seg2;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // one accepted value; Ready must stay low for exactly LAT cycles
  task automatic send(input int k, input logic [7:0] d, input logic [2:0] dp, input logic b);
    int n;
    @(negedge Clock);
    data = d; dot = dp; bz = b; v[k] = 1'b1;
    @(negedge Clock);
    v[k] = 1'b0;
    n = 0;
    while (rdy_of(k) == 1'b0 && n < 60) begin
      n++;
      @(negedge Clock);
    end
    chk($sformatf("ready_lat u%0d d%0d", k, d), n, LAT);
  endtask

  // watch the scan until every digit has been seen lit once
  task automatic capture(input int k, output logic [3:0][7:0] got, output bit ok);
    logic [3:0] seen, mask, ind;
    got  = '1;
    seen = '0;
    mask = 4'((1 << nd(k)) - 1);
    for (int c = 0; c < 300 && seen != mask; c++) begin
      @(negedge Clock);
      ind = ind_of(k);
      for (int i = 0; i < nd(k); i++)
        if (ind[i] == 1'b0 && !seen[i]) begin
          seen[i] = 1'b1;
          got[i]  = seg_of(k);
        end
    end
    ok = (seen == mask);
  endtask

  task automatic check_vec(input string name);
    vec_t            e;
    logic [3:0][7:0] got;
    bit              ok;
    e = sb.pop_front();
    capture(e.inst, got, ok);
    if (!ok) chk($sformatf("%s u%0d scan_timeout", name, e.inst), 0, 1);
    for (int i = 0; i < nd(e.inst); i++)
      chk($sformatf("%s u%0d d=%0d digit%0d", name, e.inst, e.data, i), int'(got[i]), int'(e.exp[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, low, cnt;
    vec_t e;

    // {inst, data, dotpos, blank, {digit3, digit2, digit1, digit0}}
    vecs[0] = '{0, 8'd205, 3'd0, 1'b0, {8'hFF, 8'hA4, 8'hC0, 8'h92}};
    vecs[1] = '{0, 8'd7,   3'd0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hF8}};
    vecs[2] = '{0, 8'd7,   3'd2, 1'b1, {8'hFF, 8'hFF, 8'h40, 8'hF8}};
    vecs[3] = '{0, 8'd0,   3'd0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[4] = '{0, 8'd255, 3'd1, 1'b0, {8'hFF, 8'hA4, 8'h92, 8'h12}};
    vecs[5] = '{1, 8'h80,  3'd0, 1'b0, {8'hBF, 8'hF9, 8'hA4, 8'h80}};
    vecs[6] = '{1, 8'hF9,  3'd0, 1'b1, {8'hFF, 8'hFF, 8'hBF, 8'hF8}};
    vecs[7] = '{1, 8'h7F,  3'd0, 1'b0, {8'hFF, 8'hF9, 8'hA4, 8'hF8}};
    vecs[8] = '{1, 8'hF9,  3'd0, 1'b0, {8'hBF, 8'hC0, 8'hC0, 8'hF8}};
    vecs[9] = '{2, 8'd99,  3'd0, 1'b0, {8'hFF, 8'hFF, 8'h90, 8'h90}};

    // reset state
    repeat (3) @(negedge Clock);
    chk("reset ready", int'({rdy2, rdy1, rdy0}), 7);
    chk("reset indicators", int'({ind2, ind1, ind0}), 'h1FF);
    chk("reset segments", int'({seg2, seg1, seg0}), 'hFFFFFF);
    nReset = 1'b1;
    repeat (20) @(negedge Clock);

    // table vectors through the scoreboard
    foreach (vecs[j]) begin
      sb.push_back(vecs[j]);
      send(vecs[j].inst, vecs[j].data, vecs[j].dot, vecs[j].blank);
      check_vec("vec");
    end

    // u2: overflow value; a Valid during CONVERT is dropped; old digits held
    @(negedge Clock);
    data = 8'd150; dot = 3'd1; bz = 1'b0; v[2] = 1'b1;
    e = '{2, 8'd150, 3'd1, 1'b0, {8'hFF, 8'hFF, 8'hBF, 8'hBF}};
    sb.push_back(e);
    @(negedge Clock);
    v[2] = 1'b0;
    n = 0; bad = 0;
    while (!rdy2 && n < 60) begin
      v[2] = (n == 3);
      if (n == 3) data = 8'd11;
      if (ind2 != 2'b11 && seg2 != 8'h90) bad++;
      n++;
      @(negedge Clock);
    end
    v[2] = 1'b0;
    chk("drop ready_lat", n, LAT);
    chk("drop hold_old", bad, 0);
    check_vec("drop");
    low = 0;
    repeat (30) begin
      @(negedge Clock);
      if (!rdy2) low++;
    end
    chk("drop no_requeue", low, 0);
    sb.push_back(e);
    check_vec("drop keep");

    // PWM duty over two periods
    br = 4'd0;
    repeat (40) @(negedge Clock);
    cnt = 0;
    repeat (32) begin
      @(negedge Clock);
      if (ind0 != 3'b111 || seg0 != 8'hFF) cnt++;
    end
    chk("pwm br0 lit", cnt, 0);
    br = 4'd8;
    repeat (40) @(negedge Clock);
    cnt = 0;
    repeat (32) begin
      @(negedge Clock);
      if (ind0 != 3'b111) cnt++;
    end
    chk("pwm br8 lit", cnt, 16);
    br = 4'd15;
    repeat (40) @(negedge Clock);
    cnt = 0;
    repeat (32) begin
      @(negedge Clock);
      if (ind1 != 4'b1111) cnt++;
    end
    chk("pwm br15 lit", cnt, 30);

    // reset during CONVERT
    @(negedge Clock);
    data = 8'd205; dot = 3'd0; bz = 1'b0; v[0] = 1'b1;
    @(negedge Clock);
    v[0] = 1'b0;
    repeat (2) @(negedge Clock);
    chk("pre-rst busy", int'(rdy0), 0);
    #1 nReset = 1'b0;
    #1;
    chk("rst ready", int'(rdy0), 1);
    chk("rst indicators", int'(ind0), 7);
    chk("rst segments", int'(seg0), 'hFF);
    @(negedge Clock);
    nReset = 1'b1;
    bad = 0; low = 0;
    repeat (60) begin
      @(negedge Clock);
      if (seg0 != 8'hFF) bad++;
      if (!rdy0) low++;
    end
    chk("post-rst blank", bad, 0);
    chk("post-rst idle", low, 0);
    e = '{0, 8'd7, 3'd0, 1'b0, {8'hFF, 8'hC0, 8'hC0, 8'hF8}};
    sb.push_back(e);
    send(0, 8'd7, 3'd0, 1'b0);
    check_vec("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/segment_display_driver.md
Name: segment_display_driver

Overview:
- Next-generation multiplexed 7-segment driver. Accepts a binary value over a Valid/Ready handshake and converts it to BCD with a sequential double-dabble engine instead of a combinational function.
- Adds two's-complement sign handling, leading-zero blanking, decimal point, overflow indication and PWM brightness, then scans the digits onto common-anode indicators.
- Sits between datapath logic and the board's display pins.

Parameters:
- Size, 8, data width in bits (>=2).
- Signed, 0, 1 = Data is two's complement and the leftmost digit carries the sign.
- Digits, 3, number of indicators (>=1).
- ClockPeriod_ns, 20, clock period.
- RefreshTime_ns, 20_000, full scan period across all digits.
- BrightnessBits, 4, width of the Brightness input.

Ports:
- Clock  in  1  system clock
- nReset  in  1  asynchronous active-low reset
- Valid  in  1  Data/DotPos qualifier
- Ready  out  1  high when a new value can be accepted
- Data  in  Size  value to display
- DotPos  in  clog2(Digits+1)  0 = no dot; k = dot lit on digit k-1 (digit 0 = rightmost)
- BlankZeros  in  1  suppress leading zeros
- Brightness  in  BrightnessBits  duty control; 0 = dark
- Indicators  out  Digits  digit enables, active-low
- Segments  out  8  {DP, g..a}, active-low, codes from General::BCD2ESC

Behaviour:
- Reset (async assert, sync release): Ready=1; Indicators=all ones; Segments=8'hFF; display register = all General::Empty, no dot; scan index=0; PWM counter=0; FSM=IDLE.
- FSM states: IDLE, CONVERT, FORMAT, COMMIT.
  - IDLE: Ready=1. On Valid&Ready, capture Data, DotPos and BlankZeros. If Signed and Data[Size-1]=1, capture magnitude = -Data (Size bits, so -2^(Size-1) is exact) and set the neg flag. Go to CONVERT.
  - CONVERT: Ready=0. Exactly Size cycles of shift-add-3 over a 4*Digits-bit BCD field. Bits shifted past the top set the overflow flag. Go to FORMAT.
  - FORMAT (1 cycle): apply overflow, sign and blanking (rules below). Go to COMMIT.
  - COMMIT (1 cycle): write the display register. Go to IDLE.
- Latency: accept at cycle 0; new digits are visible from cycle Size+2. Ready returns high at cycle Size+3.
- Valid while Ready=0 is ignored; nothing is queued.
- Overflow: the magnitude does not fit the available digits (Digits, or Digits-1 when Signed). All digits show General::Minus and no dot.
- Signed: the leftmost digit is Minus when neg, otherwise Empty. Magnitude uses Digits-1 digits.
- BlankZeros=1: leading zero digits become Empty, scanning from the left. Digit 0 is never blanked, and neither is the digit carrying the dot. When Signed, the Minus moves to the position just left of the most significant shown digit.
- Scan:
  - Prescale = RefreshTime_ns/ClockPeriod_ns/Digits.
  - The scan index advances on each SelectNPulse tick and wraps from Digits-1 to 0.
  - Indicators = ~(1<<index) when lit, all ones otherwise.
  - Segments = BCD2ESC(digit[index]), with DP cleared (lit) when DotPos==index+1.
  - Digits==1: no scan counter; Indicators[0] is driven only by PWM.
- PWM:
  - Free-running BrightnessBits counter; Brightness is sampled when the counter is 0.
  - Digit lit when counter < sampled Brightness. Max duty is (2^B-1)/2^B.
  - When unlit, Segments=8'hFF and Indicators=all ones.
- The display register changes only in COMMIT, so there is no tearing mid-scan. The scan continues unaffected during conversion.
- nReset asserted mid-CONVERT: conversion aborts and all outputs return to reset values.

Decomposition:
- Package General:
  - reuse Empty, Minus, BCD2ESC, clog2, clog10.
  - add typedef enum display_state_t {IDLE, CONVERT, FORMAT, COMMIT}.
  - add localparam-friendly function DefaultDigits(Size, Signed).
- Sub-module bin2bcd_serial(Clock, nReset, Start, Bin, BCD, Overflow, Done) holds the double-dabble engine.
- SelectNPulse is reused for the scan tick.

Test Plan:
- Size=8, Digits=3, Brightness=15. Send Data=205 -> Ready low for 11 cycles; digit2..0 = 2,0,5; Segments cycle 8'hA4, 8'hC0, 8'h92 (active-low).
- BlankZeros=1, Data=7, DotPos=0 -> digits Empty, Empty, 7. With DotPos=2 -> Empty, 0., 7.
- Signed=1, Digits=4, Data=8'h80 -> '-', 1, 2, 8. With BlankZeros=1 and Data=8'hF9 -> Empty, Empty, '-', 7.
- Digits=2, Data=150 -> both digits Minus. A Valid pulse asserted during CONVERT is dropped, and the display keeps its prior value until COMMIT.
- Brightness=0 -> Indicators stay all ones. Brightness=8 -> each digit lit 8 of 16 cycles, measured over 2 PWM periods.
- Assert nReset at CONVERT cycle 3 -> same cycle: Ready=1, Indicators all ones, Segments=8'hFF; after release, blank display until the next accepted value.
